// File: rtl/spi_flash_phy_pkg.sv
// rtl/spi_flash_phy_pkg.sv - shared encodings and lane helpers for the SPI flash PHY
// Purpose: format encodings, FSM state enum, lane output-enable constants and
//          small lane-mapping functions used by spi_flash_phy.
// Build option: SPI_FLASH_PHY_QUAD_EN enables the quad lane modes; without it
//          quad formats fold onto dual read.
package spi_flash_phy_pkg;

  localparam logic [1:0] FMT_SINGLE  = 2'd0;
  localparam logic [1:0] FMT_DUAL_RD = 2'd1;
  localparam logic [1:0] FMT_QUAD_RD = 2'd2;
  localparam logic [1:0] FMT_QUAD_WR = 2'd3;
  localparam int         FMT_END     = 2;

  localparam logic [3:0] OE_SINGLE  = 4'b0001;
  localparam logic [3:0] OE_READ    = 4'b0000;
  localparam logic [3:0] OE_QUAD_WR = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_DONE,
    ST_CSHI
  } state_t;

  // Lane mode actually used for a requested format.
  function automatic logic [1:0] eff_lanes(input logic [1:0] l);
`ifdef SPI_FLASH_PHY_QUAD_EN
    return l;
`else
    return l[1] ? FMT_DUAL_RD : l;
`endif
  endfunction

  function automatic logic [3:0] lane_oe(input logic [1:0] l);
    case (l)
      FMT_SINGLE:  return OE_SINGLE;
      FMT_QUAD_WR: return OE_QUAD_WR;
      default:     return OE_READ;
    endcase
  endfunction

  // Output lanes for the next bits, taken from the top nibble of the shift register.
  function automatic logic [3:0] lane_out(input logic [3:0] hi, input logic [1:0] l);
    case (l)
      FMT_SINGLE:  return {3'b000, hi[3]};
      FMT_QUAD_WR: return hi;
      default:     return 4'b0000;
    endcase
  endfunction

  // Index of the final sclk toggle (a falling edge): 2*periods-1.
  function automatic logic [4:0] last_toggle(input logic [1:0] l);
    case (l)
      FMT_SINGLE:  return 5'd15;
      FMT_DUAL_RD: return 5'd7;
      default:     return 5'd3;
    endcase
  endfunction

endpackage

// File: rtl/spi_flash_phy_tick.sv
// rtl/spi_flash_phy_tick.sv - sclk half-period tick generator
// Purpose: down-counter that fires a one-cycle tick every load+1 clk cycles.
// Ports: clk, rst_n (async active-low), restart (reload now, suppress tick),
//        load (reload value), tick (half-period boundary).
module spi_flash_phy_tick (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       restart,
  input  logic [3:0] load,
  output logic       tick
);

  logic [3:0] cnt;

  assign tick = (cnt == 4'd0) && !restart;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (restart || cnt == 4'd0) begin
      cnt <= load;
    end else begin
      cnt <= cnt - 4'd1;
    end
  end

endmodule

// File: rtl/spi_flash_phy.sv
// rtl/spi_flash_phy.sv - byte-level SPI flash PHY (mode 0, single/dual/quad lanes)
// Purpose: shifts one byte per wr strobe on sclk/cs_n/dq and returns the received byte.
// Ports: clk, rst_n (async active-low); ready/wr/din/format/prescale/dout host side;
//        sclk, cs_n, dq_o, dq_oe, dq_i flash side.
// Build option: SPI_FLASH_PHY_QUAD_EN enables quad read/write; otherwise quad
//        formats run as dual read and dq[3:2] are never driven.
module spi_flash_phy
  import spi_flash_phy_pkg::*;
#(
  parameter int CS_HOLD = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       ready,
  input  logic       wr,
  input  logic [7:0] din,
  input  logic [2:0] format,
  input  logic [3:0] prescale,
  output logic [7:0] dout,
  output logic       sclk,
  output logic       cs_n,
  output logic [3:0] dq_o,
  output logic [3:0] dq_oe,
  input  logic [3:0] dq_i
);

  state_t     state;
  logic [1:0] lanes_r;
  logic       end_r;
  logic [3:0] pre_r;
  logic [7:0] tx;
  logic [7:0] rx;
  logic [7:0] tx_shift;
  logic [7:0] rx_shift;
  logic [4:0] hcnt;
  logic [3:0] dq_o_r;
  logic [3:0] dq_oe_r;
  logic [1:0] fmt_lanes;
  logic       start;
  logic       restart;
  logic       tick;
  logic [3:0] pre_load;

  assign fmt_lanes = eff_lanes(format[1:0]);
  assign start     = (state == ST_IDLE) && wr;
  // Re-align the tick counter on byte start and before the CS-high hold.
  assign restart   = start || (state == ST_DONE);
  assign pre_load  = start ? prescale : pre_r;

  spi_flash_phy_tick u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .load    (pre_load),
    .tick    (tick)
  );

  always_comb begin
    tx_shift = tx << 1;
    rx_shift = {rx[6:0], dq_i[1]};
    case (lanes_r)
      FMT_DUAL_RD: begin
        tx_shift = tx << 2;
        rx_shift = {rx[5:0], dq_i[1:0]};
      end
      FMT_QUAD_RD, FMT_QUAD_WR: begin
        tx_shift = tx << 4;
        rx_shift = {rx[3:0], dq_i};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ready   <= 1'b1;
      cs_n    <= 1'b1;
      sclk    <= 1'b0;
      dq_o_r  <= 4'd0;
      dq_oe_r <= 4'd0;
      dout    <= 8'd0;
      tx      <= 8'd0;
      rx      <= 8'd0;
      lanes_r <= FMT_SINGLE;
      end_r   <= 1'b0;
      pre_r   <= 4'd0;
      hcnt    <= 5'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr) begin
            lanes_r <= fmt_lanes;
            end_r   <= format[FMT_END];
            pre_r   <= prescale;
            tx      <= din;
            dq_o_r  <= lane_out(din[7:4], fmt_lanes);
            dq_oe_r <= lane_oe(fmt_lanes);
            cs_n    <= 1'b0;
            ready   <= 1'b0;
            hcnt    <= 5'd0;
            state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tick) state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (tick) begin
            sclk <= ~sclk;
            if (!sclk) begin
              rx <= rx_shift;
            end else if (hcnt != last_toggle(lanes_r)) begin
              tx     <= tx_shift;
              dq_o_r <= lane_out(tx_shift[7:4], lanes_r);
            end
            // The last toggle is a fall, so sclk rests low between bytes.
            if (hcnt == last_toggle(lanes_r)) begin
              state <= ST_DONE;
            end else begin
              hcnt <= hcnt + 5'd1;
            end
          end
        end
        ST_DONE: begin
          if (end_r) begin
            cs_n    <= 1'b1;
            dq_oe_r <= 4'd0;
            hcnt    <= 5'd0;
            state   <= ST_CSHI;
          end else begin
            ready <= 1'b1;
            dout  <= rx;
            state <= ST_IDLE;
          end
        end
        ST_CSHI: begin
          if (tick) begin
            if (hcnt == 5'(CS_HOLD - 1)) begin
              ready <= 1'b1;
              dout  <= rx;
              state <= ST_IDLE;
            end else begin
              hcnt <= hcnt + 5'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SPI_FLASH_PHY_QUAD_EN
  assign dq_o  = dq_o_r;
  assign dq_oe = dq_oe_r;
`else
  logic unused_quad;
  assign dq_o        = {2'b00, dq_o_r[1:0]};
  assign dq_oe       = {2'b00, dq_oe_r[1:0]};
  assign unused_quad = ^{dq_o_r[3:2], dq_oe_r[3:2]};
`endif

endmodule

// File: tb/tb_spi_flash_phy.sv
// tb/tb_spi_flash_phy.sv - self-checking bench for spi_flash_phy
module tb_spi_flash_phy;

  localparam int CS_HOLD = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ready;
  logic       wr = 1'b0;
  logic [7:0] din = 8'd0;
  logic [2:0] format = 3'd0;
  logic [3:0] prescale = 4'd0;
  logic [7:0] dout;
  logic       sclk;
  logic       cs_n;
  logic [3:0] dq_o;
  logic [3:0] dq_oe;
  logic [3:0] dq_i = 4'd0;

  int n_cmp = 0;
  int n_bad = 0;

  spi_flash_phy dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ready    (ready),
    .wr       (wr),
    .din      (din),
    .format   (format),
    .prescale (prescale),
    .dout     (dout),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .dq_o     (dq_o),
    .dq_oe    (dq_oe),
    .dq_i     (dq_i)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] model_lanes(input logic [2:0] f);
    logic [1:0] l;
    l = f[1:0];
`ifndef SPI_FLASH_PHY_QUAD_EN
    if (l >= 2'd2) l = 2'd1;
`endif
    return l;
  endfunction

  function automatic int model_bits(input logic [2:0] f);
    logic [1:0] l;
    l = model_lanes(f);
    if (l == 2'd0) return 1;
    if (l == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] model_oe(input logic [2:0] f);
    logic [1:0] l;
    l = model_lanes(f);
    if (l == 2'd0) return 4'b0001;
    if (l == 2'd3) return 4'b1111;
    return 4'b0000;
  endfunction

  // Flash-side response: chunk k of the reply byte placed on the read lanes, noise elsewhere.
  function automatic logic [3:0] place(input logic [7:0] r, input int b, input int k);
    logic [3:0] noise;
    logic [3:0] chunk;
    noise = 4'($urandom);
    chunk = 4'((32'(r) >> (8 - b * (k + 1))) & ((1 << b) - 1));
    if (b == 1) return {noise[3:2], chunk[0], noise[0]};
    if (b == 2) return {noise[3:2], chunk[1:0]};
    return chunk;
  endfunction

  task automatic do_byte(input logic [7:0] d, input logic [2:0] f, input logic [3:0] pre,
                         input logic [7:0] resp, input bit poke, input string tag);
    int b, periods, p, exp_lat, cyc, rises, hi_len, bad_hi, cs_rise, idx, exp_rise;
    logic [7:0] mosi;
    logic [3:0] mask, exp_oe, bad_oe_val;
    bit oe_bad, cs_bad, prev_s, prev_c, seen, wmode;
    b        = model_bits(f);
    periods  = 8 / b;
    p        = int'(pre) + 1;
    exp_lat  = (1 + 2 * periods) * p + 1 + (f[2] ? CS_HOLD * p : 0);
    mask     = (b == 1) ? 4'b0001 : 4'b1111;
    exp_oe   = model_oe(f);
    wmode    = (exp_oe != 4'b0000);
    exp_rise = f[2] ? 1 : 0;
    idx = 0; rises = 0; hi_len = 0; bad_hi = 0; cs_rise = 0; cyc = 0;
    mosi = 8'd0; oe_bad = 0; cs_bad = 0; bad_oe_val = 4'd0; seen = 0;
    dq_i = place(resp, b, 0);
    wr = 1'b1; din = d; format = f; prescale = pre;
    prev_s = sclk; prev_c = cs_n;
    while (!seen && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        wr = 1'b0; din = 8'($urandom); format = 3'($urandom); prescale = 4'($urandom);
      end
      if (poke && cyc == 6) wr = 1'b1;
      if (poke && cyc == 7) wr = 1'b0;
      if (sclk && !prev_s) begin
        rises++;
        mosi = (mosi << b) | {4'b0000, dq_o & mask};
        if (dq_oe !== exp_oe) begin oe_bad = 1; bad_oe_val = dq_oe; end
        if (cs_n !== 1'b0) cs_bad = 1;
      end
      if (sclk) hi_len++;
      if (!sclk && prev_s) begin
        if (hi_len != p) bad_hi++;
        hi_len = 0;
        idx++;
        if (idx < periods) dq_i = place(resp, b, idx);
      end
      if (cs_n && !prev_c) cs_rise++;
      prev_s = sclk; prev_c = cs_n;
      if (ready) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s timeout: ready still %b after %0d cycles, required 1", tag, ready, cyc);
      return;
    end
    n_cmp++;
    if (cyc - 1 !== exp_lat) begin
      n_bad++; $display("FAIL %s latency: got %0d clk, required %0d", tag, cyc - 1, exp_lat);
    end
    n_cmp++;
    if (rises !== periods) begin
      n_bad++; $display("FAIL %s sclk rises: got %0d, required %0d", tag, rises, periods);
    end
    n_cmp++;
    if (dout !== resp) begin
      n_bad++; $display("FAIL %s dout: got %h, required %h", tag, dout, resp);
    end
    n_cmp++;
    if (oe_bad) begin
      n_bad++; $display("FAIL %s dq_oe: got %b, required %b", tag, bad_oe_val, exp_oe);
    end
    if (wmode && (model_lanes(f) == 2'd0 || model_lanes(f) == 2'd3)) begin
      n_cmp++;
      if (mosi !== d) begin
        n_bad++; $display("FAIL %s wire data: got %h, required %h", tag, mosi, d);
      end
    end
    n_cmp++;
    if (bad_hi !== 0) begin
      n_bad++; $display("FAIL %s sclk high time: %0d wrong half-periods, required each %0d clk", tag, bad_hi, p);
    end
    n_cmp++;
    if (cs_rise !== exp_rise || cs_bad) begin
      n_bad++; $display("FAIL %s cs_n framing: rises %0d (low at sclk %b), required %0d", tag, cs_rise, !cs_bad, exp_rise);
    end
    n_cmp++;
    if (cs_n !== f[2] || sclk !== 1'b0) begin
      n_bad++; $display("FAIL %s idle lines: cs_n=%b sclk=%b, required cs_n=%b sclk=0", tag, cs_n, sclk, f[2]);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    n_cmp++;
    if (ready !== 1'b1 || cs_n !== 1'b1 || sclk !== 1'b0 || dq_o !== 4'd0 || dq_oe !== 4'd0 || dout !== 8'd0) begin
      n_bad++;
      $display("FAIL %s: ready=%b cs_n=%b sclk=%b dq_o=%b dq_oe=%b dout=%h, required 1 1 0 0000 0000 00",
               tag, ready, cs_n, sclk, dq_o, dq_oe, dout);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset_held");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("reset_released");
  endtask

  task automatic test_single_byte();
    do_byte(8'h9F, 3'b100, 4'd0, 8'hEF, 1'b0, "single_9f");
  endtask

  task automatic test_frame();
    do_byte(8'h0B, 3'b000, 4'd1, 8'($urandom), 1'b0, "frame_cmd");
    for (int i = 0; i < 3; i++) do_byte(8'($urandom), 3'b000, 4'd1, 8'($urandom), 1'b0, "frame_addr");
    do_byte(8'($urandom), 3'b000, 4'd1, 8'($urandom), 1'b0, "frame_dummy");
    do_byte(8'($urandom), 3'b100, 4'd1, 8'($urandom), 1'b0, "frame_read");
    do_byte(8'h6B, 3'b000, 4'd0, 8'($urandom), 1'b0, "frame2_cmd");
    do_byte(8'($urandom), 3'b110, 4'd0, 8'($urandom), 1'b0, "frame2_quad_read");
  endtask

  task automatic test_quad_read();
    do_byte(8'($urandom), 3'b110, 4'd0, 8'hA5, 1'b0, "quad_read_a5");
    do_byte(8'($urandom), 3'b010, 4'd2, 8'($urandom), 1'b0, "quad_read_keep");
    do_byte(8'($urandom), 3'b101, 4'd1, 8'($urandom), 1'b0, "dual_read_end");
  endtask

  task automatic test_quad_write();
    do_byte(8'($urandom), 3'b011, 4'd1, 8'($urandom), 1'b0, "quad_write");
    do_byte(8'($urandom), 3'b111, 4'd0, 8'($urandom), 1'b0, "quad_write_end");
  endtask

  task automatic test_prescale();
    do_byte(8'($urandom), 3'b000, 4'd3, 8'($urandom), 1'b1, "prescale3_single");
    do_byte(8'($urandom), 3'b111, 4'd3, 8'($urandom), 1'b1, "prescale3_qw_end");
    do_byte(8'($urandom), 3'b100, 4'd15, 8'($urandom), 1'b1, "prescale15_end");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      do_byte(8'($urandom), 3'($urandom), 4'($urandom_range(0, 3)), 8'($urandom), 1'b0, "random");
  endtask

  task automatic test_reset_mid();
    int cyc;
    wr = 1'b1; din = 8'($urandom); format = 3'b000; prescale = 4'd2;
    @(negedge clk);
    wr = 1'b0;
    cyc = 0;
    while (sclk !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (sclk !== 1'b1) begin
      n_bad++; $display("FAIL reset_mid reach_shift: sclk=%b, required 1", sclk);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("reset_mid_async");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("reset_mid_release");
    do_byte(8'($urandom), 3'b100, 4'd0, 8'($urandom), 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_frame();
    test_quad_read();
    test_quad_write();
    test_prescale();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
